// File: rtl/lms_adaptive_channel_pkg.sv
// Shared widths, sample/accumulator types and the saturating narrow used by
// one channel of the 16-tap LMS adaptive FIR.
package lms_pkg;
    localparam int DW       = 14;
    localparam int TAPS     = 16;
    localparam int FRAC     = 13;
    localparam int MU_SHIFT = 8;
    localparam int AW       = 2*DW + 4;
    localparam int IW       = $clog2(TAPS);

    typedef logic signed [DW-1:0] sample_t;
    typedef logic signed [AW-1:0] acc_t;

    localparam acc_t SAT_HI = acc_t'(2**(DW-1) - 1);
    localparam acc_t SAT_LO = -SAT_HI - acc_t'(1);

    // Clamp a wide signed value into the Q1.(DW-1) sample range.
    function automatic sample_t sat(input acc_t v);
        if (v > SAT_HI) return {1'b0, {(DW-1){1'b1}}};
        if (v < SAT_LO) return {1'b1, {(DW-1){1'b0}}};
        return v[DW-1:0];
    endfunction
endpackage

// File: rtl/lms_adaptive_channel_tap_delay_line.sv
// TAPS-deep shift register of W-bit samples; taps[0] is the newest sample.
// clear (frame inactive) wins over shift.
module tap_delay_line #(
    parameter int TAPS = 16,
    parameter int W    = 14
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [W-1:0]          din,
    output logic [TAPS-1:0][W-1:0] taps
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            taps <= '0;
        else if (clear)
            taps <= '0;
        else if (shift_en)
            taps <= {taps[TAPS-2:0], din};
    end
endmodule

// File: rtl/lms_adaptive_channel.sv
// One LMS adaptive FIR channel: input/reference delay lines, weight bank,
// sequential one-tap-per-cycle MAC and a parallel LMS weight updater.
module lms_adaptive_channel
    import lms_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          head_flag,
    input  logic          shift_en,
    input  logic          filt_en,
    input  logic          wcal_en,
    input  logic [DW-1:0] din,
    input  logic [DW-1:0] ref_in,
    output logic [DW-1:0] d,
    output logic [DW-1:0] e
);
    logic [TAPS-1:0][DW-1:0] x_taps;
    logic [TAPS-1:0][DW-1:0] r_taps;
    sample_t                 w     [TAPS];
    sample_t                 w_upd [TAPS];
    acc_t                    acc;
    logic [IW-1:0]           idx;

    // filt_en > wcal_en > shift_en: the losing enables do nothing this cycle
    logic do_shift;
    assign do_shift = shift_en & ~filt_en & ~wcal_en;

    tap_delay_line #(.TAPS(TAPS), .W(DW)) u_x (
        .clk(clk), .rstn(rstn), .clear(~head_flag), .shift_en(do_shift),
        .din(din), .taps(x_taps)
    );

    tap_delay_line #(.TAPS(TAPS), .W(DW)) u_r (
        .clk(clk), .rstn(rstn), .clear(~head_flag), .shift_en(do_shift),
        .din(ref_in), .taps(r_taps)
    );

    // Only the newest reference sample feeds the error term.
    logic unused_r;
    assign unused_r = ^r_taps[TAPS-1:1];

    sample_t w_sel, x_sel, d_new, e_new;
    acc_t    prod, acc_next;

    always_comb begin
        w_sel    = w[idx];
        x_sel    = x_taps[idx];
        prod     = acc_t'(w_sel) * acc_t'(x_sel);
        acc_next = (idx == '0) ? prod : acc + prod;
        d_new    = sat(acc_next >>> FRAC);
        e_new    = sat(acc_t'($signed(r_taps[0])) - acc_t'(d_new));
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++)
            w_upd[i] = sat(acc_t'(w[i]) +
                ((acc_t'($signed(e)) * acc_t'($signed(x_taps[i]))) >>> (FRAC + MU_SHIFT)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx <= '0;
            acc <= '0;
            d   <= '0;
            e   <= '0;
            for (int i = 0; i < TAPS; i++) w[i] <= '0;
        end else if (filt_en) begin
            acc <= acc_next;
            if (idx == IW'(TAPS-1)) begin
                idx <= '0;
                d   <= d_new;
                e   <= e_new;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            // Idle or aborted pass: the next filt_en starts again at tap 0.
            idx <= '0;
            acc <= '0;
            if (wcal_en)
                for (int i = 0; i < TAPS; i++) w[i] <= w_upd[i];
        end
    end
endmodule

// File: tb/tb_lms_adaptive_channel.sv
// Scoreboard bench: a tap-array model predicts each completed filter pass,
// a separate monitor compares d/e every cycle against the latest prediction.
module tb_lms_adaptive_channel;
    localparam int DW   = 14;
    localparam int TAPS = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          head_flag = 1'b0;
    logic          shift_en = 1'b0;
    logic          filt_en = 1'b0;
    logic          wcal_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] ref_in = '0;
    logic [DW-1:0] d, e;

    lms_adaptive_channel dut (
        .clk(clk), .rstn(rstn), .head_flag(head_flag), .shift_en(shift_en),
        .filt_en(filt_en), .wcal_en(wcal_en), .din(din), .ref_in(ref_in),
        .d(d), .e(e)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int     due;
        longint d;
        longint e;
    } exp_t;
    exp_t q[$];

    // reference model state
    longint xm [TAPS];
    longint rm [TAPS];
    longint wm [TAPS];
    longint em;
    int     run;

    function automatic longint clamp(input longint v);
        if (v > 8191)  return 8191;
        if (v < -8192) return -8192;
        return v;
    endfunction

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    task automatic chk(input string nm, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            xm[i] = 0; rm[i] = 0; wm[i] = 0;
        end
        em  = 0;
        run = 0;
    endtask

    // One clock of stimulus; the model predicts what the next posedge does.
    task automatic step(input logic h, input logic s, input logic f, input logic wc,
                        input logic [DW-1:0] di, input logic [DW-1:0] ri);
        longint sum, dn, en;
        @(negedge clk); #1;
        head_flag = h; shift_en = s; filt_en = f; wcal_en = wc; din = di; ref_in = ri;
        if (f) begin
            if (run == TAPS-1) begin
                sum = 0;
                for (int i = 0; i < TAPS; i++) sum += wm[i] * xm[i];
                dn = clamp(sum >>> 13);
                en = clamp(rm[0] - dn);
                em = en;
                q.push_back('{cyc + 1, dn, en});
                run = 0;
            end else begin
                run++;
            end
        end else begin
            run = 0;
            if (wc)
                for (int i = 0; i < TAPS; i++) wm[i] = clamp(wm[i] + ((em * xm[i]) >>> 21));
        end
        if (!h) begin
            for (int i = 0; i < TAPS; i++) begin xm[i] = 0; rm[i] = 0; end
        end else if (s && !f && !wc) begin
            for (int i = TAPS-1; i > 0; i--) begin xm[i] = xm[i-1]; rm[i] = rm[i-1]; end
            xm[0] = sx(di);
            rm[0] = sx(ri);
        end
    endtask

    task automatic pass(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 1, 0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rstn = 1'b0;
        model_clear();
        q.delete();
        q.push_back('{cyc + 1, 0, 0});
        #1;
        chk("rst_d", sx(d), 0);
        chk("rst_e", sx(e), 0);
        chk("rst_idx", longint'(dut.idx), 0);
        for (int i = 0; i < TAPS; i++) chk("rst_w", longint'(dut.w[i]), 0);
        repeat (2) @(negedge clk);
        #1;
        filt_en = 1'b0; wcal_en = 1'b0; shift_en = 1'b0;
        rstn = 1'b1;
    endtask

    // monitor: adopt each prediction when it comes due, then compare
    initial begin
        exp_t   ex;
        longint cur_d = 0;
        longint cur_e = 0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    ex    = q.pop_front();
                    cur_d = ex.d;
                    cur_e = ex.e;
                end
                chk("d", sx(d), cur_d);
                chk("e", sx(e), cur_e);
            end
        end
    end

    initial begin
        int op, n;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        rstn = 1'b1;
        head_flag = 1'b1;

        // zero weights: d=0, e=0x1000
        for (int k = 0; k < TAPS; k++) step(1, 1, 0, 0, 14'h1000, 14'h1000);
        pass(TAPS);
        // one update gives w=8, then d=64, e=4032
        step(1, 0, 0, 1, '0, '0);
        pass(TAPS);
        // reference at full negative scale: e clamps to -8192
        step(1, 1, 0, 0, 14'h1000, 14'h2000);
        pass(TAPS);
        // abort after 8 cycles keeps d/e, a full pass restores 64/4032
        step(1, 1, 0, 0, 14'h1000, 14'h1000);
        pass(8);
        step(1, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, '0, '0);
        pass(TAPS);
        // flush keeps weights, zero data gives d=0, e=0
        step(0, 0, 0, 0, '0, '0);
        pass(TAPS);
        step(1, 0, 0, 0, '0, '0);
        chk("flush_keeps_w", longint'(dut.w[5]), 8);

        // randomized mix, including overlapping enables
        for (int it = 0; it < 300; it++) begin
            op = int'($urandom_range(0, 10));
            if (op <= 3) begin
                for (int k = 0; k < TAPS; k++)
                    step(1, 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)),
                         DW'($urandom), DW'($urandom));
            end else if (op == 4) begin
                n = int'($urandom_range(1, TAPS-1));
                pass(n);
                step(1, 0, 0, 0, '0, '0);
            end else if (op <= 6) begin
                step(1, 1'($urandom_range(0, 1)), 0, 1, DW'($urandom), DW'($urandom));
            end else if (op <= 9) begin
                n = int'($urandom_range(1, 6));
                for (int k = 0; k < n; k++)
                    step(1, 1, 0, 0, DW'($urandom), DW'($urandom));
            end else begin
                step(0, 1'($urandom_range(0, 1)), 0, 0, DW'($urandom), DW'($urandom));
            end
        end

        // reset in the middle of a pass
        for (int k = 0; k < TAPS; k++) step(1, 1, 0, 0, DW'($urandom), DW'($urandom));
        step(1, 0, 0, 1, '0, '0);
        pass(5);
        do_reset();
        head_flag = 1'b1;
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, DW'($urandom), DW'($urandom));
        pass(TAPS);

        repeat (3) step(1, 0, 0, 0, '0, '0);
        chk("drain", longint'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
